// File: rtl/user_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : user_button_ctrl
// Purpose  : Debounces an active-low board button and classifies presses into
//            press/release strobes, short/long press strobes and a 2-bit mode
//            index (short press advances the mode, long press clears it).
// Ports    : clk_27m       - system clock, rising edge
//            rst           - asynchronous active-high reset
//            btn_n         - raw button, active-low, asynchronous, may bounce
//            btn_level     - debounced state, 1 = pressed
//            press_pulse   - one-cycle strobe on accepted press
//            release_pulse - one-cycle strobe on accepted release
//            short_press   - one-cycle strobe on release before long threshold
//            long_press    - one-cycle strobe when hold reaches threshold
//            mode          - user mode index (modulo 4)
// Revision : 1.0 - initial release
// ============================================================================
module user_button_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 540000,
  parameter int LONG_PRESS_CYCLES = 27000000
) (
  input  logic       clk_27m,
  input  logic       rst,
  input  logic       btn_n,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic [1:0] mode
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; flops reset to the released (high) level so a
  // button held through reset is seen as a fresh press afterwards.
  // --------------------------------------------------------------------------
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_27m or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: count consecutive cycles the synchronised state disagrees with
  // the accepted level; any agreement restarts the count.
  // --------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            pressed_sync;
  logic            differ;
  logic            toggle;
  logic            level_rise;
  logic            level_fall;

  assign pressed_sync = ~sync2_q;
  assign differ       = pressed_sync != level_q;
  assign toggle       = differ && (db_cnt_q == DB_LAST);
  assign level_rise   = toggle && !level_q;
  assign level_fall   = toggle && level_q;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (differ) begin
      if (toggle) begin
        level_d  = ~level_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_27m or posedge rst) begin
    if (rst) begin
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Press classification FSM. It reacts to the level change being committed
  // this edge, so each strobe appears in the same cycle btn_level first shows
  // the new value. All strobes default low, so none can last two cycles.
  // --------------------------------------------------------------------------
  state_t            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              press_q, release_q, short_q, long_q;
  logic [1:0]        mode_q;

  always_ff @(posedge clk_27m or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      mode_q    <= 2'd0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (level_rise) begin
            press_q <= 1'b1;
            hold_q  <= '0;
            state_q <= ST_HELD;
          end
        end
        ST_HELD: begin
          // Release is checked first so it wins over a coincident threshold.
          if (level_fall) begin
            release_q <= 1'b1;
            short_q   <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (hold_q == HOLD_LAST) begin
            long_q  <= 1'b1;
            state_q <= ST_LONG;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_LONG: begin
          // Hold counter is frozen here; only a release leaves this state.
          if (level_fall) begin
            release_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Mode reacts to the strobe registered on the previous edge.
      if (short_q) begin
        mode_q <= mode_q + 2'd1;
      end else if (long_q) begin
        mode_q <= 2'd0;
      end
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign mode          = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_user_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_user_button_ctrl
// Purpose  : Directed self-checking bench for user_button_ctrl with
//            DEBOUNCE_CYCLES=8 and LONG_PRESS_CYCLES=64. Edges are numbered
//            from 1 starting with the first edge that samples a new btn_n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_user_button_ctrl;

  localparam int DB = 8;
  localparam int LP = 64;

  logic       clk_27m;
  logic       rst;
  logic       btn_n;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic [1:0] mode;

  int tests_run;
  int tests_failed;

  // Event log filled by cyc()
  int edge_no;
  int level_high_at;
  int n_level_high;
  int press_at, release_at, short_at, long_at;
  int n_press, n_rel, n_short, n_long;
  int n_bad;

  user_button_ctrl #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk_27m      (clk_27m),
    .rst          (rst),
    .btn_n        (btn_n),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .mode         (mode)
  );

  initial clk_27m = 1'b0;
  always #5 clk_27m = ~clk_27m;

  task automatic clear_log();
    edge_no       = 0;
    level_high_at = -1;
    n_level_high  = 0;
    press_at      = -1;
    release_at    = -1;
    short_at      = -1;
    long_at       = -1;
    n_press       = 0;
    n_rel         = 0;
    n_short       = 0;
    n_long        = 0;
    n_bad         = 0;
  endtask

  // Advance one clock and record strobe activity 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_27m);
    #1;
    edge_no++;
    if (btn_level) begin
      n_level_high++;
      if (level_high_at < 0) level_high_at = edge_no;
    end
    if (press_pulse)   begin n_press++; press_at   = edge_no; end
    if (release_pulse) begin n_rel++;   release_at = edge_no; end
    if (short_press)   begin n_short++; short_at   = edge_no; end
    if (long_press)    begin n_long++;  long_at    = edge_no; end
    if (press_pulse && (release_pulse || short_press || long_press)) n_bad++;
    if (long_press && (release_pulse || short_press)) n_bad++;
    if (short_press && !release_pulse) n_bad++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    btn_n = 1'b1;
    #12;
    tests_run++;
    if ({btn_level, press_pulse, release_pulse, short_press, long_press} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {btn_level, press_pulse, release_pulse, short_press, long_press});
    end
    tests_run++;
    if (mode !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_mode: got %0d expected 0", mode);
    end
    @(posedge clk_27m);
    #1;
    rst = 1'b0;
    clear_log();
    run(5);
    tests_run++;
    if (n_level_high != 0 || n_press != 0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: level_cycles=%0d presses=%0d expected 0 0",
               n_level_high, n_press);
    end
  endtask

  // 100-cycle hold: press at edge 10, long at edge 10+64, release only.
  task automatic test_long_hold();
    clear_log();
    btn_n = 1'b0;
    run(100);
    tests_run++;
    if (level_high_at != 10) begin
      tests_failed++;
      $display("FAIL long_level_rise: edge %0d expected 10", level_high_at);
    end
    tests_run++;
    if (n_press != 1 || press_at != 10) begin
      tests_failed++;
      $display("FAIL long_press_pulse: count %0d at %0d expected 1 at 10", n_press, press_at);
    end
    tests_run++;
    if (n_long != 1 || long_at != 74) begin
      tests_failed++;
      $display("FAIL long_strobe: count %0d at %0d expected 1 at 74", n_long, long_at);
    end
    tests_run++;
    if (mode !== 2'd0 || n_short != 0 || n_rel != 0) begin
      tests_failed++;
      $display("FAIL long_hold_misc: mode %0d short %0d rel %0d expected 0 0 0",
               mode, n_short, n_rel);
    end
    clear_log();
    btn_n = 1'b1;
    run(20);
    tests_run++;
    if (n_rel != 1 || release_at != 10 || n_short != 0 || n_long != 0) begin
      tests_failed++;
      $display("FAIL long_release: rel %0d at %0d short %0d long %0d expected 1 at 10 0 0",
               n_rel, release_at, n_short, n_long);
    end
  endtask

  // Low for 20 cycles then high: short press 10 edges after release.
  task automatic test_short_press();
    clear_log();
    btn_n = 1'b0;
    run(20);
    tests_run++;
    if (n_press != 1 || press_at != 10) begin
      tests_failed++;
      $display("FAIL short_press_pulse: count %0d at %0d expected 1 at 10", n_press, press_at);
    end
    clear_log();
    btn_n = 1'b1;
    run(10);
    tests_run++;
    if (mode !== 2'd0) begin
      tests_failed++;
      $display("FAIL short_mode_same_cycle: got %0d expected 0", mode);
    end
    run(5);
    tests_run++;
    if (n_rel != 1 || release_at != 10 || n_short != 1 || short_at != 10 || n_long != 0) begin
      tests_failed++;
      $display("FAIL short_release: rel %0d@%0d short %0d@%0d long %0d expected 1@10 1@10 0",
               n_rel, release_at, n_short, short_at, n_long);
    end
    tests_run++;
    if (mode !== 2'd1) begin
      tests_failed++;
      $display("FAIL short_mode: got %0d expected 1", mode);
    end
  endtask

  // Toggle every 3 cycles for 40 cycles, then stable high.
  task automatic test_bounce();
    clear_log();
    for (int i = 0; i < 40; i++) begin
      btn_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      cyc();
    end
    btn_n = 1'b1;
    run(20);
    tests_run++;
    if (n_level_high != 0 || (n_press + n_rel + n_short + n_long) != 0) begin
      tests_failed++;
      $display("FAIL bounce: level_cycles %0d strobes %0d expected 0 0",
               n_level_high, n_press + n_rel + n_short + n_long);
    end
    tests_run++;
    if (mode !== 2'd1) begin
      tests_failed++;
      $display("FAIL bounce_mode: got %0d expected 1", mode);
    end
  endtask

  task automatic do_short();
    btn_n = 1'b0;
    run(20);
    btn_n = 1'b1;
    run(15);
  endtask

  task automatic test_mode_wrap();
    logic [1:0] exp_mode [4];
    exp_mode[0] = 2'd1;
    exp_mode[1] = 2'd2;
    exp_mode[2] = 2'd3;
    exp_mode[3] = 2'd0;
    #2;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_short();
      tests_run++;
      if (mode !== exp_mode[k]) begin
        tests_failed++;
        $display("FAIL mode_wrap_%0d: got %0d expected %0d", k, mode, exp_mode[k]);
      end
    end
    do_short();
    do_short();
    clear_log();
    btn_n = 1'b0;
    run(80);
    tests_run++;
    if (n_long != 1 || mode !== 2'd0) begin
      tests_failed++;
      $display("FAIL mode_long_clear: long %0d mode %0d expected 1 0", n_long, mode);
    end
    clear_log();
    btn_n = 1'b1;
    run(15);
    tests_run++;
    if (n_rel != 1 || n_short != 0 || mode !== 2'd0) begin
      tests_failed++;
      $display("FAIL mode_long_release: rel %0d short %0d mode %0d expected 1 0 0",
               n_rel, n_short, mode);
    end
  endtask

  // Raw release sampled first at edge 65 -> level falls at edge 74, the
  // same edge the long strobe would otherwise fire.
  task automatic test_release_on_threshold();
    clear_log();
    btn_n = 1'b0;
    run(64);
    btn_n = 1'b1;
    run(20);
    tests_run++;
    if (n_short != 1 || short_at != 74 || n_rel != 1 || release_at != 74) begin
      tests_failed++;
      $display("FAIL threshold_short: short %0d@%0d rel %0d@%0d expected 1@74 1@74",
               n_short, short_at, n_rel, release_at);
    end
    tests_run++;
    if (n_long != 0) begin
      tests_failed++;
      $display("FAIL threshold_long: count %0d expected 0", n_long);
    end
    tests_run++;
    if (mode !== 2'd1) begin
      tests_failed++;
      $display("FAIL threshold_mode: got %0d expected 1", mode);
    end
  endtask

  task automatic test_reset_mid_long();
    clear_log();
    btn_n = 1'b0;
    run(80);
    tests_run++;
    if (n_long != 1 || btn_level !== 1'b1) begin
      tests_failed++;
      $display("FAIL midlong_setup: long %0d level %b expected 1 1", n_long, btn_level);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({btn_level, press_pulse, release_pulse, short_press, long_press} !== 5'b0 ||
        mode !== 2'd0) begin
      tests_failed++;
      $display("FAIL midlong_async_reset: outputs %b mode %0d expected 00000 0",
               {btn_level, press_pulse, release_pulse, short_press, long_press}, mode);
    end
    clear_log();
    run(3);
    rst = 1'b0;
    clear_log();
    run(15);
    tests_run++;
    if (n_press != 1 || press_at != 10) begin
      tests_failed++;
      $display("FAIL midlong_repress: count %0d at %0d expected 1 at 10", n_press, press_at);
    end
    tests_run++;
    if (n_rel != 0 || n_short != 0 || n_long != 0) begin
      tests_failed++;
      $display("FAIL midlong_no_strobe: rel %0d short %0d long %0d expected 0 0 0",
               n_rel, n_short, n_long);
    end
    btn_n = 1'b1;
    run(15);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_log();
    test_reset();
    test_long_hold();
    test_short_press();
    test_bounce();
    test_mode_wrap();
    test_release_on_threshold();
    test_reset_mid_long();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Strobe exclusivity monitored across all scenarios.
  always @(posedge clk_27m) begin
    #2;
    if (!rst && press_pulse && (release_pulse || short_press || long_press)) begin
      $display("FAIL strobe_exclusive: press %b rel %b short %b long %b expected press alone",
               press_pulse, release_pulse, short_press, long_press);
    end
  end

endmodule
`default_nettype wire

// File: doc/user_button_ctrl.md
USER_BUTTON_CTRL -- requirements
Module: user_button_ctrl

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 540000, stable-input cycles needed to accept a level change (20 ms at 27 MHz); legal range >= 2.
REQ-002 SHALL provide parameter LONG_PRESS_CYCLES, default 27000000, hold cycles after accepted press that qualify a long press (1 s at 27 MHz); legal range > DEBOUNCE_CYCLES.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk_27m  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 btn_n  input  1  raw board button, active-low, asynchronous to clk_27m, may bounce.
REQ-007 btn_level  output  1  debounced button state, 1 = pressed.
REQ-008 press_pulse  output  1  one-cycle strobe on accepted press.
REQ-009 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-010 short_press  output  1  one-cycle strobe on release of a press shorter than LONG_PRESS_CYCLES.
REQ-011 long_press  output  1  one-cycle strobe when hold reaches LONG_PRESS_CYCLES.
REQ-012 mode  output  2  user mode index, controlled by short/long presses.

Function
REQ-013 SHALL synchronise btn_n through a 2-flop synchroniser whose flops reset to 1 (released); no other logic SHALL sample btn_n directly.
REQ-014 Debounce counter SHALL increment each cycle the synchronised pressed state differs from btn_level and clear to 0 in any cycle they match.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 while still differing, btn_level SHALL toggle on the next edge and the counter SHALL clear.
REQ-016 A clean raw edge held stable SHALL change btn_level exactly 2+DEBOUNCE_CYCLES clock edges after the first edge sampling the new raw value.
REQ-017 Any bounce shorter than DEBOUNCE_CYCLES cycles SHALL leave btn_level unchanged and restart the count.
REQ-018 Press FSM states: IDLE (released), HELD (pressed, below long threshold), LONG (pressed, long already reported).
REQ-019 IDLE -> HELD in the cycle btn_level rises; press_pulse SHALL be 1 in the first cycle btn_level reads 1; hold counter cleared to 0.
REQ-020 In HELD the hold counter SHALL increment each cycle; at value LONG_PRESS_CYCLES-1, next edge SHALL assert long_press for one cycle and enter LONG (long_press exactly LONG_PRESS_CYCLES cycles after press_pulse).
REQ-021 HELD -> IDLE on btn_level fall: release_pulse and short_press both 1 in the first cycle btn_level reads 0.
REQ-022 LONG -> IDLE on btn_level fall: release_pulse 1, short_press stays 0.
REQ-023 If btn_level falls in the same cycle the hold counter hits its threshold, release wins: short_press asserted, long_press not asserted.
REQ-024 Hold counter SHALL saturate/stop in LONG; no repeat long_press while held.
REQ-025 mode SHALL increment modulo 4 (3 -> 0 wrap) in the cycle after short_press, and SHALL clear to 0 in the cycle after long_press.
REQ-026 All strobes SHALL be registered, mutually exclusive except release_pulse+short_press, and never high two consecutive cycles.
REQ-027 Counter widths SHALL be $clog2 of their parameter; no overflow at any legal parameter value.

Reset
REQ-028 On rst=1, asynchronously: synchroniser flops 1, btn_level 0, all strobes 0, mode 0, counters 0, FSM IDLE.
REQ-029 Reset asserted mid-press SHALL abort without any strobe; after release of rst with button still held, a fresh press SHALL be accepted after 2+DEBOUNCE_CYCLES edges.

Verification (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=64)
REQ-030 btn_n 1->0 held 100 cycles -> btn_level rises 10 edges after first sampled low, press_pulse one cycle, long_press exactly 64 cycles after press_pulse, mode 0.
REQ-031 btn_n low 20 cycles then high -> press_pulse, then release_pulse+short_press together 10 edges after release, mode 0->1.
REQ-032 Bounce: btn_n toggles every 3 cycles for 40 cycles, then stable high -> btn_level stays 0, no strobes.
REQ-033 Four short presses -> mode 1,2,3,0 (wrap); then one long press from mode 2 -> mode 0, release gives release_pulse only.
REQ-034 Release aligned so btn_level falls on threshold cycle -> short_press 1, long_press 0.
REQ-035 rst pulsed while LONG -> outputs zero immediately, no release_pulse; button held through reset -> press_pulse 10 edges after rst deasserts.
